sram_port_arbiter: RTL and testbench

//  Shares one sram_4k instance between the instruction-fetch port (read-only) and the LSU port (read/write).
//  - Round-robin arbitration between the two requesters.
//  - Sequences the SRAM: byte-enabled LSU stores become read-modify-write, since the SRAM writes whole words only.
//  - Sits between the core's fetch/LSU logic and sram_4k.

---
 rtl/sram_port_arbiter_pkg.sv | 12 +
 rtl/sram_port_arbiter_if.sv | 49 ++++
 rtl/byte_lane_merge.sv | 21 ++
 rtl/sram_port_arbiter.sv | 113 +++++++++++
 tb/tb_sram_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the SRAM port arbiter slice.
// The arbiter FSM states and requester identities live here so the bench can reuse them.
package sram_port_arbiter_pkg;

  localparam int ARCH       = 32;
  localparam int ARCH_BYTES = ARCH / 8;
  localparam int ADDR_SHIFT = $clog2(ARCH_BYTES);

  typedef enum logic [1:0] {IDLE, RD, RMW_RD, WR} sram_arb_state_e;
  typedef enum logic {PORT_IF, PORT_LSU} sram_port_e;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Bundle of fetch, LSU and SRAM-side signals around the shared sram_4k.
// The slave modport is the arbiter's view; master is the surrounding core plus SRAM.
interface sram_port_arbiter_if
  import sram_port_arbiter_pkg::*;
#(
  parameter int DATA_W = ARCH,
  parameter int ADDR_W = 12
) ();

  logic              if_req_in;
  logic [ADDR_W-1:0] if_addr_in;
  logic              if_gnt_out;
  logic              if_rvalid_out;
  logic [DATA_W-1:0] if_rdata_out;

  logic                lsu_req_in;
  logic                lsu_we_in;
  logic [DATA_W/8-1:0] lsu_be_in;
  logic [ADDR_W-1:0]   lsu_addr_in;
  logic [DATA_W-1:0]   lsu_wdata_in;
  logic                lsu_gnt_out;
  logic                lsu_rvalid_out;
  logic [DATA_W-1:0]   lsu_rdata_out;

  logic [ADDR_W-1:0] sram_addr_a_out;
  logic [DATA_W-1:0] sram_din_a_out;
  logic              sram_we_a_out;
  logic [ADDR_W-1:0] sram_addr_b_out;
  logic [DATA_W-1:0] sram_dout_b_in;

  modport slave (
    input  if_req_in, if_addr_in,
    output if_gnt_out, if_rvalid_out, if_rdata_out,
    input  lsu_req_in, lsu_we_in, lsu_be_in, lsu_addr_in, lsu_wdata_in,
    output lsu_gnt_out, lsu_rvalid_out, lsu_rdata_out,
    output sram_addr_a_out, sram_din_a_out, sram_we_a_out, sram_addr_b_out,
    input  sram_dout_b_in
  );

  modport master (
    output if_req_in, if_addr_in,
    input  if_gnt_out, if_rvalid_out, if_rdata_out,
    output lsu_req_in, lsu_we_in, lsu_be_in, lsu_addr_in, lsu_wdata_in,
    input  lsu_gnt_out, lsu_rvalid_out, lsu_rdata_out,
    input  sram_addr_a_out, sram_din_a_out, sram_we_a_out, sram_addr_b_out,
    output sram_dout_b_in
  );

endinterface

// File: rtl/byte_lane_merge.sv
// Combinational byte-lane merge: lanes with be set take the new word, the rest keep the old word.
// Kept separate so it can also serve sram_4k byte enables later.
module byte_lane_merge
  import sram_port_arbiter_pkg::*;
#(
  parameter int DATA_W = ARCH
) (
  input  logic [DATA_W-1:0]   i_oldWord,
  input  logic [DATA_W-1:0]   i_newWord,
  input  logic [DATA_W/8-1:0] i_be,
  output logic [DATA_W-1:0]   o_merged
);

  always_comb begin
    o_merged = i_oldWord;
    for (int i = 0; i < DATA_W / 8; i++) begin
      if (i_be[i]) o_merged[8*i +: 8] = i_newWord[8*i +: 8];
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one sram_4k between instruction fetch and the LSU.
// Partial-byte stores are sequenced as read-modify-write because the SRAM writes whole words.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int DATA_W = ARCH,
  parameter int ADDR_W = 12
) (
  input logic                 clk,
  input logic                 rst,
  sram_port_arbiter_if.slave  bus
);

  localparam int BE_W = DATA_W / 8;

  sram_arb_state_e   r_state;
  sram_port_e        r_rrPtr;
  sram_port_e        r_txnOwner;
  logic [ADDR_W-1:0] r_txnAddr;
  logic [DATA_W-1:0] r_txnWdata;
  logic [BE_W-1:0]   r_txnBe;
  logic [DATA_W-1:0] r_merge;
  logic [DATA_W-1:0] r_ifRdata;
  logic [DATA_W-1:0] r_lsuRdata;
  logic              r_ifRvalid;
  logic              r_lsuRvalid;

  logic              w_idle;
  logic              w_ifGnt;
  logic              w_lsuGnt;
  logic [DATA_W-1:0] w_mergedWord;

  // Grants only happen in IDLE and never while reset is asserted.
  assign w_idle   = (r_state == IDLE) && !rst;
  assign w_ifGnt  = w_idle && bus.if_req_in  && (!bus.lsu_req_in || r_rrPtr == PORT_IF);
  assign w_lsuGnt = w_idle && bus.lsu_req_in && (!bus.if_req_in  || r_rrPtr == PORT_LSU);

  byte_lane_merge #(.DATA_W(DATA_W)) u_merge (
    .i_oldWord (bus.sram_dout_b_in),
    .i_newWord (r_txnWdata),
    .i_be      (r_txnBe),
    .o_merged  (w_mergedWord)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rrPtr     <= PORT_LSU;
      r_txnOwner  <= PORT_IF;
      r_txnAddr   <= '0;
      r_txnWdata  <= '0;
      r_txnBe     <= '0;
      r_merge     <= '0;
      r_ifRdata   <= '0;
      r_lsuRdata  <= '0;
      r_ifRvalid  <= 1'b0;
      r_lsuRvalid <= 1'b0;
    end else begin
      r_ifRvalid  <= 1'b0;
      r_lsuRvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_ifGnt) begin
            r_rrPtr    <= PORT_LSU;
            r_txnOwner <= PORT_IF;
            r_txnAddr  <= bus.if_addr_in;
            r_state    <= RD;
          end else if (w_lsuGnt) begin
            r_rrPtr    <= PORT_IF;
            r_txnOwner <= PORT_LSU;
            r_txnAddr  <= bus.lsu_addr_in;
            r_txnWdata <= bus.lsu_wdata_in;
            r_txnBe    <= bus.lsu_be_in;
            // A store with no lanes enabled retires at grant with no SRAM access.
            if (!bus.lsu_we_in)        r_state <= RD;
            else if (&bus.lsu_be_in)   r_state <= WR;
            else if (|bus.lsu_be_in)   r_state <= RMW_RD;
            else                       r_state <= IDLE;
          end
        end
        RD: begin
          if (r_txnOwner == PORT_IF) begin
            r_ifRdata  <= bus.sram_dout_b_in;
            r_ifRvalid <= 1'b1;
          end else begin
            r_lsuRdata  <= bus.sram_dout_b_in;
            r_lsuRvalid <= 1'b1;
          end
          r_state <= IDLE;
        end
        RMW_RD: begin
          r_merge <= w_mergedWord;
          r_state <= WR;
        end
        WR:      r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.if_gnt_out      = w_ifGnt;
  assign bus.lsu_gnt_out     = w_lsuGnt;
  assign bus.if_rvalid_out   = r_ifRvalid;
  assign bus.if_rdata_out    = r_ifRdata;
  assign bus.lsu_rvalid_out  = r_lsuRvalid;
  assign bus.lsu_rdata_out   = r_lsuRdata;

  assign bus.sram_addr_a_out = r_txnAddr;
  assign bus.sram_addr_b_out = r_txnAddr;
  assign bus.sram_we_a_out   = (r_state == WR) && !rst;
  assign bus.sram_din_a_out  = (r_state == WR) ? ((&r_txnBe) ? r_txnWdata : r_merge) : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed vector table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_sram_port_arbiter;
  import sram_port_arbiter_pkg::*;

  localparam int DATA_W = ARCH;
  localparam int ADDR_W = 12;
  localparam int BE_W   = ARCH_BYTES;
  localparam int DEPTH  = (1 << ADDR_W) / ARCH_BYTES;
  localparam int RAND_CYCLES = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  sram_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural sram_4k: async read, word write on posedge, plus a bench-only preload path.
  logic [DATA_W-1:0] mem [DEPTH];
  logic              plEn = 1'b0;
  logic [ADDR_W-1:0] plAddr = '0;
  logic [DATA_W-1:0] plData = '0;
  int cyc = 0;
  int weCount = 0;
  int lastWeCyc = -1;

  assign bus.sram_dout_b_in = mem[bus.sram_addr_b_out[ADDR_W-1:ADDR_SHIFT]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.sram_we_a_out) begin
      mem[bus.sram_addr_a_out[ADDR_W-1:ADDR_SHIFT]] <= bus.sram_din_a_out;
      weCount   <= weCount + 1;
      lastWeCyc <= cyc;
    end else if (plEn) begin
      mem[plAddr[ADDR_W-1:ADDR_SHIFT]] <= plData;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                             input logic [DATA_W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
    end
  endtask

  task automatic idleInputs();
    bus.if_req_in    = 1'b0;
    bus.if_addr_in   = '0;
    bus.lsu_req_in   = 1'b0;
    bus.lsu_we_in    = 1'b0;
    bus.lsu_be_in    = '0;
    bus.lsu_addr_in  = '0;
    bus.lsu_wdata_in = '0;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    plEn = 1'b1; plAddr = a; plData = d;
    @(negedge clk);
    plEn = 1'b0;
  endtask

  typedef struct {
    string             name;
    logic              isLsu;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              doPreload;
    logic [DATA_W-1:0] preloadVal;
    logic [DATA_W-1:0] expData;
    int                expWrites;
    int                expLat;
  } vec_t;

  function automatic vec_t mkVec(input string name, input logic isLsu, input logic we,
                                 input logic [BE_W-1:0] be, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] wdata, input logic doPreload,
                                 input logic [DATA_W-1:0] preloadVal,
                                 input logic [DATA_W-1:0] expData,
                                 input int expWrites, input int expLat);
    vec_t v;
    v.name = name; v.isLsu = isLsu; v.we = we; v.be = be; v.addr = addr;
    v.wdata = wdata; v.doPreload = doPreload; v.preloadVal = preloadVal;
    v.expData = expData; v.expWrites = expWrites; v.expLat = expLat;
    return v;
  endfunction

  // One isolated transaction: grant in the issue cycle, then data or SRAM commit at fixed latency.
  task automatic applyStimulus(input vec_t v);
    int tGnt;
    int wBefore;
    if (v.doPreload) preload(v.addr, v.preloadVal);
    @(negedge clk);
    wBefore = weCount;
    if (v.isLsu) begin
      bus.lsu_req_in = 1'b1; bus.lsu_we_in = v.we; bus.lsu_be_in = v.be;
      bus.lsu_addr_in = v.addr; bus.lsu_wdata_in = v.wdata;
    end else begin
      bus.if_req_in = 1'b1; bus.if_addr_in = v.addr;
    end
    #1;
    tGnt = cyc;
    checkOutput($sformatf("%s_gnt", v.name), v.isLsu ? bus.lsu_gnt_out : bus.if_gnt_out, 1);
    checkOutput($sformatf("%s_othergnt", v.name), v.isLsu ? bus.if_gnt_out : bus.lsu_gnt_out, 0);
    @(negedge clk);
    idleInputs();
    if (!v.isLsu || !v.we) begin
      checkOutput($sformatf("%s_rv_early", v.name), v.isLsu ? bus.lsu_rvalid_out : bus.if_rvalid_out, 0);
      @(negedge clk);
      checkOutput($sformatf("%s_rvalid", v.name), v.isLsu ? bus.lsu_rvalid_out : bus.if_rvalid_out, 1);
      checkOutput($sformatf("%s_rdata", v.name), v.isLsu ? bus.lsu_rdata_out : bus.if_rdata_out, v.expData);
    end else begin
      repeat (3) @(negedge clk);
      checkOutput($sformatf("%s_writes", v.name), DATA_W'(weCount - wBefore), DATA_W'(v.expWrites));
      if (v.expWrites > 0)
        checkOutput($sformatf("%s_latency", v.name), DATA_W'(lastWeCyc - tGnt), DATA_W'(v.expLat));
      checkOutput($sformatf("%s_mem", v.name), mem[v.addr[ADDR_W-1:ADDR_SHIFT]], v.expData);
    end
  endtask

  vec_t vecs[8];

  logic [DATA_W-1:0] refMem [16];
  localparam logic [ADDR_W-1:0] RAND_BASE = 12'h300;

  function automatic int refIdx(input logic [ADDR_W-1:0] a);
    return (int'(a) - int'(RAND_BASE)) / ARCH_BYTES;
  endfunction

  initial begin
    int wBefore;
    idleInputs();

    // Reset held across an LSU full-word store request: nothing may be granted or written.
    rst = 1'b1;
    bus.lsu_req_in = 1'b1; bus.lsu_we_in = 1'b1; bus.lsu_be_in = '1;
    bus.lsu_addr_in = 12'h080; bus.lsu_wdata_in = 32'h0BAD0BAD;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      checkOutput("rst_we", bus.sram_we_a_out, 0);
      checkOutput("rst_gnt", bus.lsu_gnt_out, 0);
    end
    checkOutput("rst_writes", DATA_W'(weCount), 0);
    @(negedge clk);
    idleInputs();
    rst = 1'b0;
    #1;
    checkOutput("post_rst_if_gnt", bus.if_gnt_out, 0);
    checkOutput("post_rst_lsu_gnt", bus.lsu_gnt_out, 0);
    checkOutput("post_rst_if_rvalid", bus.if_rvalid_out, 0);
    checkOutput("post_rst_lsu_rvalid", bus.lsu_rvalid_out, 0);
    checkOutput("post_rst_if_rdata", bus.if_rdata_out, 0);
    checkOutput("post_rst_lsu_rdata", bus.lsu_rdata_out, 0);
    checkOutput("post_rst_we", bus.sram_we_a_out, 0);
    checkOutput("post_rst_din", bus.sram_din_a_out, 0);
    checkOutput("post_rst_addr_a", DATA_W'(bus.sram_addr_a_out), 0);
    checkOutput("post_rst_addr_b", DATA_W'(bus.sram_addr_b_out), 0);

    // Contention straight out of reset: LSU owns the pointer, then grants alternate.
    bus.if_req_in = 1'b1;  bus.if_addr_in = 12'h100;
    bus.lsu_req_in = 1'b1; bus.lsu_we_in = 1'b0; bus.lsu_addr_in = 12'h200;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checkOutput($sformatf("cont_lsu_gnt_%0d", k), bus.lsu_gnt_out, DATA_W'(k % 4 == 0));
      checkOutput($sformatf("cont_if_gnt_%0d", k), bus.if_gnt_out, DATA_W'(k % 4 == 2));
      checkOutput($sformatf("cont_lsu_rv_%0d", k), bus.lsu_rvalid_out, DATA_W'(k % 4 == 2));
      checkOutput($sformatf("cont_if_rv_%0d", k), bus.if_rvalid_out, DATA_W'(k > 0 && k % 4 == 0));
    end
    @(negedge clk);
    idleInputs();
    repeat (2) @(negedge clk);

    vecs[0] = mkVec("fetch_010", 0, 0, '0, 12'h010, '0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    vecs[1] = mkVec("pstore_0101", 1, 1, 4'b0101, 12'h020, 32'hAABBCCDD, 1, 32'h11223344, 32'h11BB33DD, 1, 2);
    vecs[2] = mkVec("pstore_0010", 1, 1, 4'b0010, 12'h024, 32'hAABBCCDD, 1, 32'h11223344, 32'h1122CC44, 1, 2);
    vecs[3] = mkVec("fstore_040", 1, 1, 4'b1111, 12'h040, 32'hCAFEF00D, 0, '0, 32'hCAFEF00D, 1, 1);
    vecs[4] = mkVec("fetch_043", 0, 0, '0, 12'h043, '0, 0, '0, 32'hCAFEF00D, 0, 0);
    vecs[5] = mkVec("noop_store", 1, 1, 4'b0000, 12'h020, 32'hFFFFFFFF, 0, '0, 32'h11BB33DD, 0, 0);
    vecs[6] = mkVec("lsu_load_020", 1, 0, 4'b0000, 12'h020, '0, 0, '0, 32'h11BB33DD, 0, 0);
    vecs[7] = mkVec("pstore_1000", 1, 1, 4'b1000, 12'h044, 32'h12345678, 1, 32'h00000000, 32'h12000000, 1, 2);
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // No-op store retires at grant, so a fetch is grantable the very next cycle.
    @(negedge clk);
    wBefore = weCount;
    bus.lsu_req_in = 1'b1; bus.lsu_we_in = 1'b1; bus.lsu_be_in = '0;
    bus.lsu_addr_in = 12'h020; bus.lsu_wdata_in = 32'hFFFFFFFF;
    #1;
    checkOutput("noop_gnt", bus.lsu_gnt_out, 1);
    @(negedge clk);
    idleInputs();
    bus.if_req_in = 1'b1; bus.if_addr_in = 12'h020;
    #1;
    checkOutput("noop_next_gnt", bus.if_gnt_out, 1);
    @(negedge clk);
    idleInputs();
    @(negedge clk);
    checkOutput("noop_next_rvalid", bus.if_rvalid_out, 1);
    checkOutput("noop_next_rdata", bus.if_rdata_out, 32'h11BB33DD);
    checkOutput("noop_writes", DATA_W'(weCount - wBefore), 0);

    // Reset during the read half of a read-modify-write drops the store entirely.
    preload(12'h080, 32'hA5A5A5A5);
    @(negedge clk);
    wBefore = weCount;
    bus.lsu_req_in = 1'b1; bus.lsu_we_in = 1'b1; bus.lsu_be_in = 4'b0011;
    bus.lsu_addr_in = 12'h080; bus.lsu_wdata_in = 32'h55667788;
    #1;
    checkOutput("midrst_gnt", bus.lsu_gnt_out, 1);
    @(negedge clk);
    idleInputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("midrst_writes", DATA_W'(weCount - wBefore), 0);
    checkOutput("midrst_mem", mem[12'h080 >> ADDR_SHIFT], 32'hA5A5A5A5);
    checkOutput("midrst_rvalid", bus.lsu_rvalid_out, 0);

    // Randomized traffic over 16 words; reset left the pointer on LSU and both rdata at zero.
    for (int k = 0; k < 16; k++) begin
      refMem[k] = $urandom;
      preload(RAND_BASE + ADDR_W'(4 * k), refMem[k]);
    end
    begin
      logic              ifPend, lsuPend, rrLsu;
      logic [ADDR_W-1:0] ifA, lsuA;
      logic              lsuWe;
      logic [BE_W-1:0]   lsuBe;
      logic [DATA_W-1:0] lsuD, ifExp, lsuExp, lastIf, lastLsu;
      logic              expIfG, expLsuG;
      int nextFree, ifDue, lsuDue, weDue, idx;
      ifPend = 0; lsuPend = 0; rrLsu = 1;
      ifA = '0; lsuA = '0; lsuWe = 0; lsuBe = '0; lsuD = '0;
      ifExp = '0; lsuExp = '0; lastIf = '0; lastLsu = '0;
      nextFree = 0; ifDue = -1; lsuDue = -1; weDue = -1;
      for (int c = 0; c < RAND_CYCLES; c++) begin
        @(negedge clk);
        if (!ifPend && $urandom_range(0, 2) == 0) begin
          ifPend = 1;
          ifA = RAND_BASE + ADDR_W'(4 * $urandom_range(0, 15) + $urandom_range(0, 3));
        end
        if (!lsuPend && $urandom_range(0, 2) == 0) begin
          lsuPend = 1;
          lsuA  = RAND_BASE + ADDR_W'(4 * $urandom_range(0, 15) + $urandom_range(0, 3));
          lsuWe = 1'($urandom_range(0, 1));
          case ($urandom_range(0, 3))
            0:       lsuBe = '0;
            1:       lsuBe = '1;
            default: lsuBe = BE_W'($urandom);
          endcase
          lsuD = $urandom;
        end
        bus.if_req_in = ifPend;    bus.if_addr_in = ifA;
        bus.lsu_req_in = lsuPend;  bus.lsu_we_in = lsuWe; bus.lsu_be_in = lsuBe;
        bus.lsu_addr_in = lsuA;    bus.lsu_wdata_in = lsuD;
        #1;
        if (ifDue == c)  lastIf  = ifExp;
        if (lsuDue == c) lastLsu = lsuExp;
        expIfG  = (c >= nextFree) && ifPend  && (!lsuPend || !rrLsu);
        expLsuG = (c >= nextFree) && lsuPend && (!ifPend || rrLsu);
        checkOutput("rand_if_gnt", bus.if_gnt_out, DATA_W'(expIfG));
        checkOutput("rand_lsu_gnt", bus.lsu_gnt_out, DATA_W'(expLsuG));
        checkOutput("rand_we", bus.sram_we_a_out, DATA_W'(weDue == c));
        checkOutput("rand_if_rvalid", bus.if_rvalid_out, DATA_W'(ifDue == c));
        checkOutput("rand_lsu_rvalid", bus.lsu_rvalid_out, DATA_W'(lsuDue == c));
        checkOutput("rand_if_rdata", bus.if_rdata_out, lastIf);
        checkOutput("rand_lsu_rdata", bus.lsu_rdata_out, lastLsu);
        if (expIfG) begin
          ifExp = refMem[refIdx(ifA)];
          ifDue = c + 2; nextFree = c + 2; rrLsu = 1; ifPend = 0;
        end else if (expLsuG) begin
          idx = refIdx(lsuA);
          rrLsu = 0; lsuPend = 0;
          if (!lsuWe) begin
            lsuExp = refMem[idx]; lsuDue = c + 2; nextFree = c + 2;
          end else if (lsuBe == '1) begin
            refMem[idx] = lsuD; weDue = c + 1; nextFree = c + 2;
          end else if (lsuBe == '0) begin
            nextFree = c + 1;
          end else begin
            for (int b = 0; b < BE_W; b++)
              if (lsuBe[b]) refMem[idx][8*b +: 8] = lsuD[8*b +: 8];
            weDue = c + 2; nextFree = c + 3;
          end
        end
      end
    end
    idleInputs();
    repeat (4) @(negedge clk);
    for (int k = 0; k < 16; k++)
      checkOutput($sformatf("rand_mem_%0d", k), mem[(RAND_BASE >> ADDR_SHIFT) + k], refMem[k]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
